// File: rtl/rollo_ct_drain.sv
// rollo_ct_drain: reads ROLLO-II ciphertext words from the encrypt core and streams them
// through a first-word-fall-through skid FIFO with credit-limited read issue.
module rollo_ct_drain #(
  parameter int NUM_WORDS  = 148,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              enc_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              m_valid,
  output logic [31:0]       m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_WORDS - 1);
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN, ST_DONE} state_t;
  state_t state, state_nx;
  logic enc_ready_q, in_flight, start, pop, last_issue, has_credit;
  logic [ADDR_W-1:0] issue_cnt, sent_cnt;
  logic [PW:0] wr_ptr, rd_ptr, fifo_count;
  logic [31:0] mem [FIFO_DEPTH];
  assign start = enc_ready & ~enc_ready_q;
  assign last_issue = issue_cnt == LAST;
  assign fifo_count = wr_ptr - rd_ptr;
  // a read in flight already owns a FIFO slot, so it counts against credit
  assign has_credit = ({1'b0, fifo_count} + {{(PW+1){1'b0}}, in_flight}) < (PW+2)'(FIFO_DEPTH);
  assign m_valid = fifo_count != '0;
  assign m_data = m_valid ? mem[rd_ptr[PW-1:0]] : '0;
  assign m_last = m_valid && sent_cnt == LAST;
  assign pop = m_valid & m_ready;
  assign rd_addr = issue_cnt;
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  state_nx = start ? ST_FETCH : ST_IDLE;
      ST_FETCH: state_nx = (rd_en && last_issue) ? ST_DRAIN : ST_FETCH;
      ST_DRAIN: state_nx = (pop && m_last) ? ST_DONE : ST_DRAIN;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_comb begin
    busy = state == ST_FETCH || state == ST_DRAIN;
    done = state == ST_DONE;
    rd_en = state == ST_FETCH && has_credit;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) begin
      enc_ready_q <= 1'b0;
      in_flight <= 1'b0;
      issue_cnt <= '0;
      sent_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      enc_ready_q <= enc_ready;
      in_flight <= rd_en;
      if (state == ST_IDLE && start) begin
        issue_cnt <= '0;
        sent_cnt <= '0;
      end else begin
        if (rd_en) issue_cnt <= last_issue ? '0 : issue_cnt + ADDR_W'(1);
        if (pop) sent_cnt <= m_last ? '0 : sent_cnt + ADDR_W'(1);
      end
      if (in_flight) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  always_ff @(posedge clk)
    if (in_flight) mem[wr_ptr[PW-1:0]] <= rd_data;
endmodule

// File: tb/tb_rollo_ct_drain.sv
// tb_rollo_ct_drain: drain scenarios checked against a word-level model of the stream and read credit.
module tb_rollo_ct_drain;
  localparam int N = 148;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;
  logic clk = 0, rst_b, enc_ready, m_ready;
  logic rd_en, m_valid, m_last, busy, done;
  logic [11:0] rd_addr;
  logic [31:0] rd_data, m_data;
  logic enc2, mr2, rd_en2, mv2, ml2, busy2, done2;
  logic [0:0] rd_addr2;
  logic [31:0] rd_data2, md2;
  int n_cmp = 0, n_bad = 0;
  int ph = P_IDLE, prev_er = 0, exp_idx = 0, issued = 0, iss_lag = 0;
  int done_cnt = 0;
  logic [31:0] first_data = 0, last_data = 0;
  always #5 clk = ~clk;
  rollo_ct_drain #(.NUM_WORDS(N), .FIFO_DEPTH(DEPTH), .ADDR_W(12)) dut (
    .clk(clk), .rst_b(rst_b), .enc_ready(enc_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .busy(busy), .done(done));
  rollo_ct_drain #(.NUM_WORDS(2), .FIFO_DEPTH(2), .ADDR_W(1)) dut2 (
    .clk(clk), .rst_b(rst_b), .enc_ready(enc2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(rd_data2), .m_valid(mv2), .m_data(md2), .m_last(ml2),
    .m_ready(mr2), .busy(busy2), .done(done2));
  // core RAM: word[i] = C0DE_0000 + i, one cycle of read latency, garbage otherwise
  always @(posedge clk) begin
    rd_data <= rd_en ? 32'hC0DE_0000 + 32'(rd_addr) : 32'hDEAD_BEEF;
    rd_data2 <= rd_en2 ? 32'hC0DE_0000 + 32'(rd_addr2) : 32'hDEAD_BEEF;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // word-level model: a drain is a sequence of N reads limited to DEPTH outstanding words,
  // each read becoming visible two cycles later, then a done cycle after the last accept
  always @(negedge clk) begin
    int iss_start;
    logic fin;
    if (!rst_b) begin
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      chk("rst_m_valid", 32'(m_valid), 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", 32'(m_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      ph = P_IDLE; prev_er = 0; exp_idx = 0; issued = 0; iss_lag = 0;
    end else begin
      fin = 0;
      iss_start = issued;
      chk("busy", 32'(busy), 32'(ph == P_BUSY));
      chk("done", 32'(done), 32'(ph == P_DONE));
      if (done) done_cnt++;
      chk("rd_en", 32'(rd_en), 32'(ph == P_BUSY && issued < N && issued - exp_idx < DEPTH));
      if (rd_en) begin
        chk("rd_addr", 32'(rd_addr), issued);
        issued++;
      end
      chk("m_valid", 32'(m_valid), 32'(iss_lag > exp_idx));
      if (m_valid) begin
        chk("m_data", m_data, 32'hC0DE_0000 + exp_idx);
        chk("m_last", 32'(m_last), 32'(exp_idx == N - 1));
        if (m_ready) begin
          if (exp_idx == 0) first_data = m_data;
          if (m_last) last_data = m_data;
          if (exp_idx == N - 1) fin = 1;
          exp_idx++;
        end
      end
      iss_lag = iss_start;
      if (ph == P_DONE) ph = P_IDLE;
      else if (fin) ph = P_DONE;
      else if (ph == P_IDLE && enc_ready && !prev_er) begin
        ph = P_BUSY; issued = 0; exp_idx = 0; iss_lag = 0;
      end
      prev_er = int'(enc_ready);
    end
  end
  task automatic start_drain();
    done_cnt = 0;
    @(posedge clk); #1 enc_ready = 1;
  endtask
  task automatic gap();
    enc_ready = 0;
    m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
  endtask
  // mode 0: hold m_ready, 1: random m_ready, 2: re-trigger at word 60, 3: stop at word 70
  task automatic run(input int mode, output int lat);
    int tog = 0;
    lat = 0;
    for (int k = 1; k <= 3000; k++) begin
      @(posedge clk); #1;
      if (mode == 1) m_ready = 1'($urandom_range(0, 1));
      if (mode == 2) begin
        if (tog == 0 && exp_idx >= 60) begin enc_ready = 0; tog = 1; end
        else if (tog == 1) begin enc_ready = 1; tog = 2; end
      end
      if (mode == 3 && exp_idx >= 70) begin lat = k; return; end
      @(negedge clk); #1;
      if (done) begin lat = k; return; end
    end
    n_cmp++; n_bad++;
    $display("FAIL run_timeout: mode %0d got no done, expected done within 3000 cycles", mode);
  endtask
  initial begin
    int lat, nw, w0_k, w1_k, dn_k, dn2;
    logic [31:0] w0_d, w1_d;
    logic w0_l, w1_l;
    rst_b = 0; enc_ready = 0; m_ready = 1; enc2 = 0; mr2 = 1;
    repeat (3) @(posedge clk);
    #1 rst_b = 1;
    @(negedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(m_valid), 0);
    // basic drain
    start_drain();
    run(0, lat);
    chk("t1_latency", lat, 151);
    chk("t1_words", exp_idx, N);
    chk("t1_first", first_data, 32'hC0DE_0000);
    chk("t1_last", last_data, 32'hC0DE_0093);
    chk("t1_done_cnt", done_cnt, 1);
    @(posedge clk); #1;
    chk("t1_busy_after", 32'(busy), 0);
    chk("t1_done_after", 32'(done), 0);
    gap();
    // backpressure
    m_ready = 0;
    start_drain();
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    chk("t2_reads", issued, 4);
    chk("t2_rd_en", 32'(rd_en), 0);
    chk("t2_valid", 32'(m_valid), 1);
    chk("t2_hold", m_data, 32'hC0DE_0000);
    @(posedge clk); #1 m_ready = 1;
    run(0, lat);
    chk("t2_words", exp_idx, N);
    chk("t2_done_cnt", done_cnt, 1);
    gap();
    // random backpressure, three drains
    for (int d = 0; d < 3; d++) begin
      start_drain();
      run(1, lat);
      chk("t3_words", exp_idx, N);
      chk("t3_last", last_data, 32'hC0DE_0093);
      chk("t3_done_cnt", done_cnt, 1);
      gap();
    end
    // re-trigger while busy
    start_drain();
    run(2, lat);
    chk("t4_words", exp_idx, N);
    chk("t4_latency", lat, 151);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_busy_after", 32'(busy), 0);
    chk("t4_done_cnt", done_cnt, 1);
    gap();
    // reset mid-drain
    start_drain();
    run(3, lat);
    chk("t5_pre_valid", 32'(m_valid), 1);
    #1 rst_b = 0; enc_ready = 0;
    #1;
    chk("t5_async_valid", 32'(m_valid), 0);
    chk("t5_async_busy", 32'(busy), 0);
    chk("t5_async_rd_en", 32'(rd_en), 0);
    chk("t5_async_data", m_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_b = 1;
    @(posedge clk); #1;
    chk("t5_idle_busy", 32'(busy), 0);
    start_drain();
    run(0, lat);
    chk("t5_latency", lat, 151);
    chk("t5_first", first_data, 32'hC0DE_0000);
    chk("t5_words", exp_idx, N);
    gap();
    // two-word instance
    nw = 0; w0_k = -1; w1_k = -1; dn_k = -1; dn2 = 0;
    w0_d = 0; w1_d = 0; w0_l = 0; w1_l = 0;
    @(posedge clk); #1 enc2 = 1;
    for (int k = 0; k <= 12; k++) begin
      @(negedge clk); #1;
      if (mv2) begin
        if (nw == 0) begin w0_k = k; w0_d = md2; w0_l = ml2; end
        else if (nw == 1) begin w1_k = k; w1_d = md2; w1_l = ml2; end
        nw++;
      end
      if (done2) begin dn_k = k; dn2++; end
      @(posedge clk);
    end
    chk("t6_words", nw, 2);
    chk("t6_w0_cycle", w0_k, 3);
    chk("t6_w0_data", w0_d, 32'hC0DE_0000);
    chk("t6_w0_last", 32'(w0_l), 0);
    chk("t6_w1_cycle", w1_k, 4);
    chk("t6_w1_data", w1_d, 32'hC0DE_0001);
    chk("t6_w1_last", 32'(w1_l), 1);
    chk("t6_done_cycle", dn_k, 5);
    chk("t6_done_cnt", dn2, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
